// File: rtl/prog_mem_loader.sv
// prog_mem_loader: program memory with a byte-stream loader and a registered fetch port.
// Define PROG_MEM_HALT_DETECT_EN to end a load on the first stored HALT word.
module prog_mem_loader #(
  parameter int NBITS_O   = 11,
  parameter int NBITS_D   = 16,
  parameter int CELDAS    = 512,
  parameter int NBITS_OPC = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_start,
  input  logic               i_load_stop,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_fetch_en,
  input  logic [NBITS_O-1:0] i_Addr,
  output logic [NBITS_D-1:0] o_Data,
  output logic               o_load_busy,
  output logic               o_load_done,
  output logic [NBITS_O:0]   o_word_count,
  output logic               o_overflow
);

  localparam int BYTES = NBITS_D / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int AW    = (CELDAS > 1) ? $clog2(CELDAS) : 1;

  localparam logic [BCW-1:0]   LAST_B = BCW'(BYTES - 1);
  localparam logic [NBITS_O:0] LAST_W = (NBITS_O + 1)'(CELDAS - 1);
  localparam logic [NBITS_O:0] DEPTH  = (NBITS_O + 1)'(CELDAS);

`ifdef PROG_MEM_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [BCW-1:0]     byte_cnt;
  logic [NBITS_D-1:0] asm_q;
  logic [NBITS_D-1:0] asm_shift;
  logic [NBITS_O:0]   word_cnt;
  logic               overflow_q;
  logic               halt;

  logic [NBITS_D-1:0] mem [2**AW];

  // First byte of a word ends up in the most significant position.
  assign asm_shift = (asm_q << 8) | NBITS_D'(i_rx_data);
  assign halt = HALT_EN && (asm_q[NBITS_D-1 -: NBITS_OPC] == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      asm_q      <= '0;
      word_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (i_load_start) begin
            state      <= RECV;
            byte_cnt   <= '0;
            asm_q      <= '0;
            word_cnt   <= '0;
            overflow_q <= 1'b0;
          end
        end
        RECV: begin
          if (i_load_stop) begin
            state <= DONE;
          end else if (i_rx_valid) begin
            asm_q <= asm_shift;
            if (byte_cnt == LAST_B) begin
              byte_cnt <= '0;
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          if (halt) begin
            state <= DONE;
          end else if (word_cnt == LAST_W) begin
            state      <= DONE;
            overflow_q <= 1'b1;
          end else if (i_rx_valid) begin
            // Byte arriving during the write opens the next word.
            asm_q <= asm_shift;
            if (byte_cnt == LAST_B) begin
              state <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= RECV;
            end
          end else begin
            state <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && state == WRITE) begin
      mem[word_cnt[AW-1:0]] <= asm_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_Data <= '0;
    end else if (i_fetch_en && !o_load_busy) begin
      o_Data <= ({1'b0, i_Addr} < DEPTH) ? mem[i_Addr[AW-1:0]] : '0;
    end
  end

  assign o_load_busy  = (state == RECV) || (state == WRITE);
  assign o_load_done  = (state == DONE);
  assign o_word_count = word_cnt;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed bench for prog_mem_loader.
// Runs a default-depth instance and a CELDAS=4 instance on shared stimulus.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_load_start = 1'b0;
  logic        i_load_stop = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_fetch_en = 1'b0;
  logic [10:0] i_Addr = 11'd0;

  logic [15:0] a_data, b_data;
  logic        a_busy, b_busy;
  logic        a_done, b_done;
  logic [11:0] a_cnt, b_cnt;
  logic        a_ovf, b_ovf;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] p2;
  logic [15:0] exp_m2;
  logic [11:0] exp_cnt;

  always #5 clk = ~clk;

  prog_mem_loader u_dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_load_start (i_load_start),
    .i_load_stop  (i_load_stop),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_fetch_en   (i_fetch_en),
    .i_Addr       (i_Addr),
    .o_Data       (a_data),
    .o_load_busy  (a_busy),
    .o_load_done  (a_done),
    .o_word_count (a_cnt),
    .o_overflow   (a_ovf)
  );

  prog_mem_loader #(.CELDAS(4)) u_dut_small (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_load_start (i_load_start),
    .i_load_stop  (i_load_stop),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_fetch_en   (i_fetch_en),
    .i_Addr       (i_Addr),
    .o_Data       (b_data),
    .o_load_busy  (b_busy),
    .o_load_done  (b_done),
    .o_word_count (b_cnt),
    .o_overflow   (b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic start;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic stop;
    i_load_stop = 1'b1;
    tick();
    i_load_stop = 1'b0;
  endtask

  task automatic fetch(input logic [10:0] a);
    i_fetch_en = 1'b1;
    i_Addr     = a;
    tick();
    i_fetch_en = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_data", a_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_ovf_b", b_ovf, 0);
    i_reset = 1'b0;
    tick();

    // basic two-word load
    start();
    check("busy_rise", a_busy, 1);
    send(8'h10);
    send(8'h01);
    send(8'h28);
    send(8'h02);
    tick();
    check("cnt_2", a_cnt, 2);
    stop();
    check("done_1", a_done, 1);
    check("busy_0", a_busy, 0);
    fetch(11'd0);
    check("mem0", a_data, 16'h1001);
    fetch(11'd1);
    check("mem1", a_data, 16'h2802);
    fetch(11'd600);
    check("oob_addr", a_data, 0);

    // HALT word handling
    fetch(11'd2);
    p2 = a_data;
`ifdef PROG_MEM_HALT_DETECT_EN
    exp_cnt = 12'd2;
    exp_m2  = p2;
`else
    exp_cnt = 12'd3;
    exp_m2  = 16'h1808;
`endif
    start();
    send(8'h10);
    send(8'h01);
    send(8'h00);
    send(8'h05);
    send(8'h18);
    send(8'h08);
    tick();
    stop();
    check("halt_cnt", a_cnt, exp_cnt);
    check("halt_done", a_done, 1);
    fetch(11'd1);
    check("halt_mem1", a_data, 16'h0005);
    fetch(11'd2);
    check("halt_mem2", a_data, exp_m2);

    // partial word discarded on stop
    start();
    send(8'hAB);
    stop();
    check("part_cnt", a_cnt, 0);
    check("part_done", a_done, 1);
    start();
    send(8'h77);
    i_rx_data   = 8'h66;
    i_rx_valid  = 1'b1;
    i_load_stop = 1'b1;
    tick();
    i_rx_valid  = 1'b0;
    i_load_stop = 1'b0;
    check("stopwin_cnt", a_cnt, 0);
    check("stopwin_done", a_done, 1);
    fetch(11'd0);
    check("nowrite_mem0", a_data, 16'h1001);

    // reset in the middle of a load
    start();
    send(8'h10);
    send(8'h01);
    send(8'h28);
    check("mid_cnt_1", a_cnt, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("mid_busy", a_busy, 0);
    check("mid_cnt", a_cnt, 0);
    check("mid_done", a_done, 0);
    fetch(11'd0);
    check("mid_mem0", a_data, 16'h1001);

    // fetch is blocked while busy
    start();
    check("busy_fetch", a_busy, 1);
    fetch(11'd1);
    check("hold_data", a_data, 16'h1001);
    stop();

    // overflow on the 4-deep instance
    start();
    send(8'h11); send(8'h11);
    send(8'h22); send(8'h22);
    send(8'h33); send(8'h33);
    send(8'h44); send(8'h44);
    send(8'h55); send(8'h55);
    tick();
    check("ovf_cnt", b_cnt, 4);
    check("ovf_flag", b_ovf, 1);
    check("ovf_done", b_done, 1);
    check("ovf_busy", b_busy, 0);
    fetch(11'd0);
    check("ovf_m0", b_data, 16'h1111);
    fetch(11'd1);
    check("ovf_m1", b_data, 16'h2222);
    fetch(11'd2);
    check("ovf_m2", b_data, 16'h3333);
    fetch(11'd3);
    check("ovf_m3", b_data, 16'h4444);
    fetch(11'd4);
    check("ovf_oob", b_data, 0);
    start();
    check("restart_done", b_done, 0);
    check("restart_ovf", b_ovf, 0);
    check("restart_busy", b_busy, 1);
    check("restart_cnt", b_cnt, 0);
    stop();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
